// File: rtl/vga_pkg.sv
// Shared types and constants for the 640x480@60 VGA timing generator:
// line/frame geometry, coordinate and colour widths, and the colour-bar table.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int BAR_W   = 80;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  localparam rgb_t BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Equivalent to col / BAR_W for the visible range, built from compares.
  function automatic logic [2:0] bar_index(input coord_t col);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col >= coord_t'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: fetch coordinates, sync/enable
// strobes and colour. The generator is the master; the display sink is the slave.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_ce;
  rgb_t   pixel_in;
  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   de;
  rgb_t   rgb;
  logic   frame_start;

  modport master (
    input  pix_ce, pixel_in,
    output x, y, hsync, vsync, de, rgb, frame_start
  );

  modport slave (
    output pix_ce, pixel_in,
    input  x, y, hsync, vsync, de, rgb, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Enabled wrap counter for one VGA axis: counts 0..LAST, then wraps to 0.
// tc flags the terminal value so the next axis can chain on it.
module vga_axis_counter #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == LAST);

  // NOTE: non-blocking updates make the H and V counters sample each other's
  // pre-edge values, so the V step and the H wrap happen on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: x/y fetch counters plus one registered decode
// stage. Build option VGA_TEST_PATTERN_EN replaces pixel_in with colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int V_VIS_LINES  = V_VIS,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  vga_timing_gen_if.master bus
);

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t H_VIS_END    = coord_t'(H_VIS);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_VIS + H_FP);
  localparam coord_t H_SYNC_LAST  = coord_t'(H_VIS + H_FP + H_SYNC - 1);

  localparam coord_t V_LAST       =
    coord_t'(V_VIS_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES - 1);
  localparam coord_t V_VIS_END    = coord_t'(V_VIS_LINES);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_VIS_LINES + V_FP_LINES);
  localparam coord_t V_SYNC_LAST  = coord_t'(V_VIS_LINES + V_FP_LINES + V_SYNC_LINES - 1);

  coord_t h_count;
  coord_t v_count;
  logic   h_tc;
  logic   v_tc;
  rgb_t   pix_src;
  logic   hs_dec;
  logic   vs_dec;
  logic   de_dec;

  logic   hsync_q;
  logic   vsync_q;
  logic   de_q;
  rgb_t   rgb_q;
  logic   frame_start_q;

  vga_axis_counter #(.WIDTH(COORD_W), .LAST(H_LAST)) u_h_counter (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (bus.pix_ce),
    .count (h_count),
    .tc    (h_tc)
  );

  vga_axis_counter #(.WIDTH(COORD_W), .LAST(V_LAST)) u_v_counter (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (bus.pix_ce & h_tc),
    .count (v_count),
    .tc    (v_tc)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic unused_pixel_in;
  assign unused_pixel_in = ^bus.pixel_in;
  assign pix_src         = BAR_COLOURS[bar_index(h_count)];
`else
  assign pix_src = bus.pixel_in;
`endif

  // Decode the coordinate currently presented; it is registered on the same
  // pix_ce edge that advances the counters, giving one pixel of latency.
  assign hs_dec = !((h_count >= H_SYNC_FIRST) && (h_count <= H_SYNC_LAST));
  assign vs_dec = !((v_count >= V_SYNC_FIRST) && (v_count <= V_SYNC_LAST));
  assign de_dec = (h_count < H_VIS_END) && (v_count < V_VIS_END);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= bus.pix_ce & h_tc & v_tc;
      if (bus.pix_ce) begin
        hsync_q <= hs_dec;
        vsync_q <= vs_dec;
        de_q    <= de_dec;
        rgb_q   <= de_dec ? pix_src : '0;
      end
    end
  end

  assign bus.x           = h_count;
  assign bus.y           = v_count;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.rgb         = rgb_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with full horizontal timing and a shortened
// 10-line frame (4 visible, 2 porch, 2 sync, 2 porch) so a whole frame is cheap.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  always #5 sys_clk = ~sys_clk;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .V_VIS_LINES  (4),
    .V_FP_LINES   (2),
    .V_SYNC_LINES (2),
    .V_BP_LINES   (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Running tallies over pixel steps; tests compare deltas.
  int   de_cnt    = 0;
  int   vs_low    = 0;
  int   hs_low    = 0;
  logic last_fs   = 1'b0;
  int   fs_cycles = 0;

  always @(negedge sys_clk) begin
    if (bus.frame_start === 1'b1) fs_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_src(input int xd, input logic [11:0] pin);
`ifdef VGA_TEST_PATTERN_EN
    case (xd / 80)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
`else
    if (xd < 0) return 12'h000;
    return pin;
`endif
  endfunction

  // One pixel period: pix_ce high for one sys_clk, low for three.
  task automatic step(input int n, input logic [11:0] pin);
    for (int i = 0; i < n; i++) begin
      bus.pixel_in = pin;
      bus.pix_ce   = 1'b1;
      @(posedge sys_clk);
      #1;
      bus.pix_ce = 1'b0;
      last_fs    = bus.frame_start;
      if (bus.de === 1'b1)    de_cnt++;
      if (bus.vsync === 1'b0) vs_low++;
      if (bus.hsync === 1'b0) hs_low++;
      repeat (3) @(posedge sys_clk);
      #1;
    end
  endtask

  // Reset is held with pix_ce high to show the strobe is ignored.
  task automatic do_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n  = 1'b0;
    bus.pix_ce = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic release_reset();
    sys_rst_n  = 1'b1;
    bus.pix_ce = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int ex, input int ey,
                               input logic ehs, input logic evs, input logic ede,
                               input logic [11:0] erg);
    check({tag, " x"},     32'(bus.x),     32'(ex));
    check({tag, " y"},     32'(bus.y),     32'(ey));
    check({tag, " hsync"}, 32'(bus.hsync), 32'(ehs));
    check({tag, " vsync"}, 32'(bus.vsync), 32'(evs));
    check({tag, " de"},    32'(bus.de),    32'(ede));
    check({tag, " rgb"},   32'(bus.rgb),   32'(erg));
  endtask

  typedef struct {
    int          adv;
    logic [11:0] pin;
    int          ex;
    int          ey;
    logic        ehs;
    logic        evs;
    logic        ede;
    int          exd;
    logic        efs;
  } vec_t;

  vec_t vt [16];

  initial begin
    int fs_base;
    int de_base;
    int vs_base;
    int hs_base;

    // adv, pixel_in, x, y, hsync, vsync, de, delayed x, frame_start
    vt[0]  = '{0,    12'hA5C, 0,   0, 1'b1, 1'b1, 1'b0, 0,   1'b0};
    vt[1]  = '{1,    12'hA5C, 1,   0, 1'b1, 1'b1, 1'b1, 0,   1'b0};
    vt[2]  = '{80,   12'h123, 81,  0, 1'b1, 1'b1, 1'b1, 80,  1'b0};
    vt[3]  = '{480,  12'h3C7, 561, 0, 1'b1, 1'b1, 1'b1, 560, 1'b0};
    vt[4]  = '{79,   12'h5A5, 640, 0, 1'b1, 1'b1, 1'b1, 639, 1'b0};
    vt[5]  = '{1,    12'hA5C, 641, 0, 1'b1, 1'b1, 1'b0, 640, 1'b0};
    vt[6]  = '{15,   12'hA5C, 656, 0, 1'b1, 1'b1, 1'b0, 655, 1'b0};
    vt[7]  = '{1,    12'hA5C, 657, 0, 1'b0, 1'b1, 1'b0, 656, 1'b0};
    vt[8]  = '{95,   12'hA5C, 752, 0, 1'b0, 1'b1, 1'b0, 751, 1'b0};
    vt[9]  = '{1,    12'hA5C, 753, 0, 1'b1, 1'b1, 1'b0, 752, 1'b0};
    vt[10] = '{47,   12'hA5C, 0,   1, 1'b1, 1'b1, 1'b0, 799, 1'b0};
    vt[11] = '{1,    12'h0F0, 1,   1, 1'b1, 1'b1, 1'b1, 0,   1'b0};
    vt[12] = '{4000, 12'h777, 1,   6, 1'b1, 1'b0, 1'b0, 0,   1'b0};
    vt[13] = '{799,  12'h777, 0,   7, 1'b1, 1'b0, 1'b0, 799, 1'b0};
    vt[14] = '{801,  12'h777, 1,   8, 1'b1, 1'b1, 1'b0, 0,   1'b0};
    vt[15] = '{1599, 12'hA5C, 0,   0, 1'b1, 1'b1, 1'b0, 799, 1'b1};

    sys_rst_n    = 1'b0;
    bus.pix_ce   = 1'b0;
    bus.pixel_in = 12'h000;

    do_reset();
    release_reset();
    fs_base = fs_cycles;
    de_base = de_cnt;
    vs_base = vs_low;
    hs_base = hs_low;

    // Vectors are cumulative from reset and cover exactly one frame.
    for (int i = 0; i < 16; i++) begin
      step(vt[i].adv, vt[i].pin);
      check_outputs($sformatf("vec%0d", i), vt[i].ex, vt[i].ey, vt[i].ehs, vt[i].evs,
                    vt[i].ede, vt[i].ede ? exp_src(vt[i].exd, vt[i].pin) : 12'h000);
      if (vt[i].adv > 0)
        check($sformatf("vec%0d frame_start", i), 32'(last_fs), 32'(vt[i].efs));
    end

    check("frame de pixels",      32'(de_cnt - de_base),    32'd2560);
    check("frame vsync low",      32'(vs_low - vs_base),    32'd1600);
    check("frame hsync low",      32'(hs_low - hs_base),    32'd960);
    check("frame_start cycles",   32'(fs_cycles - fs_base), 32'd1);

    // Mid-frame reset aborts the frame with no frame_start on release.
    step(1900, 12'h456);
    check("pre-reset x", 32'(bus.x), 32'd300);
    check("pre-reset y", 32'(bus.y), 32'd2);
    fs_base = fs_cycles;
    do_reset();
    check_outputs("in-reset", 0, 0, 1'b1, 1'b1, 1'b0, 12'h000);
    check("in-reset frame_start", 32'(bus.frame_start), 32'd0);
    release_reset();
    step(1, 12'h9E1);
    check_outputs("post-reset", 1, 0, 1'b1, 1'b1, 1'b1, exp_src(0, 12'h9E1));
    check("post-reset frame_start", 32'(fs_cycles - fs_base), 32'd0);

    // Without pix_ce everything holds, even as pixel_in changes.
    step(10, 12'h0F1);
    bus.pixel_in = 12'hABC;
    repeat (100) @(posedge sys_clk);
    #1;
    check_outputs("hold", 11, 0, 1'b1, 1'b1, 1'b1, exp_src(10, 12'h0F1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
